// File: rtl/bna_pkg.sv
// rtl/bna_pkg.sv - shared lane geometry defaults and unpacker FSM state encoding
package bna_pkg;

  localparam int LANE_SHIFT_DEF = 17;
  localparam int PSUM_WIDTH_DEF = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/packed_lane_split.sv
// rtl/packed_lane_split.sv - splits one packed dual-product word into two signed lane values
module packed_lane_split import bna_pkg::*; #(
  parameter int MAC_ACC_WIDTH = 48,
  parameter int LANE_SHIFT    = LANE_SHIFT_DEF,
  parameter int PSUM_WIDTH    = PSUM_WIDTH_DEF
) (
  input  logic [MAC_ACC_WIDTH-1:0] i_packed,
  output logic [PSUM_WIDTH-1:0]    o_lo,
  output logic [PSUM_WIDTH-1:0]    o_hi
);

  // A negative low lane borrowed one from the high lane when packed; add it back.
  always_comb begin
    o_lo = PSUM_WIDTH'($signed(i_packed[LANE_SHIFT-1:0]));
    o_hi = PSUM_WIDTH'(($signed(i_packed) >>> LANE_SHIFT)
                       + $signed({{(MAC_ACC_WIDTH-1){1'b0}}, i_packed[LANE_SHIFT-1]}));
  end

endmodule

// File: rtl/packed_psum_unpacker.sv
// rtl/packed_psum_unpacker.sv - accumulates decoded lane products per job and hands off both sums
module packed_psum_unpacker import bna_pkg::*; #(
  parameter int MAC_ACC_WIDTH = 48,
  parameter int LANE_SHIFT    = LANE_SHIFT_DEF,
  parameter int PSUM_WIDTH    = PSUM_WIDTH_DEF,
  parameter int LEN_WIDTH     = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [LEN_WIDTH-1:0]     i_len,
  input  logic                     i_valid,
  input  logic [MAC_ACC_WIDTH-1:0] i_packed,
  output logic                     o_ready,
  output logic [PSUM_WIDTH-1:0]    o_psum_0,
  output logic [PSUM_WIDTH-1:0]    o_psum_1,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_busy
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [LEN_WIDTH-1:0]    r_len;
  logic [LEN_WIDTH-1:0]    r_cnt;
  logic [PSUM_WIDTH-1:0]   r_acc0;
  logic [PSUM_WIDTH-1:0]   r_acc1;
  logic [PSUM_WIDTH-1:0]   w_lo;
  logic [PSUM_WIDTH-1:0]   w_hi;
  logic [LEN_WIDTH-1:0]    w_len_eff;
  logic [LEN_WIDTH-1:0]    w_cnt_inc;
  logic                    w_load;
  logic                    w_beat;

  packed_lane_split #(
    .MAC_ACC_WIDTH (MAC_ACC_WIDTH),
    .LANE_SHIFT    (LANE_SHIFT),
    .PSUM_WIDTH    (PSUM_WIDTH)
  ) u_split (
    .i_packed (i_packed),
    .o_lo     (w_lo),
    .o_hi     (w_hi)
  );

  assign w_len_eff = (i_len == '0) ? LEN_WIDTH'(1) : i_len;
  assign w_cnt_inc = r_cnt + LEN_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_ready     = 1'b0;
    o_valid     = 1'b0;
    o_busy      = 1'b0;
    w_load      = 1'b0;
    w_beat      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_ACC;
        end
      end
      ST_ACC: begin
        o_ready = 1'b1;
        o_busy  = 1'b1;
        if (i_valid) begin
          w_beat = 1'b1;
          if (w_cnt_inc == r_len) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        o_valid = 1'b1;
        o_busy  = 1'b1;
        // A start coinciding with the handoff skips IDLE to keep back-to-back jobs dense.
        if (i_ready) begin
          if (i_start) begin
            w_load      = 1'b1;
            w_state_nxt = ST_ACC;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len  <= '0;
      r_cnt  <= '0;
      r_acc0 <= '0;
      r_acc1 <= '0;
    end else if (w_load) begin
      r_len  <= w_len_eff;
      r_cnt  <= '0;
      r_acc0 <= '0;
      r_acc1 <= '0;
    end else if (w_beat) begin
      r_cnt  <= w_cnt_inc;
      r_acc0 <= r_acc0 + w_lo;
      r_acc1 <= r_acc1 + w_hi;
    end
  end

  assign o_psum_0 = r_acc0;
  assign o_psum_1 = r_acc1;

endmodule

// File: tb/tb_packed_psum_unpacker.sv
// tb/tb_packed_psum_unpacker.sv - directed self-checking bench for packed_psum_unpacker
module tb_packed_psum_unpacker;

  localparam int LW = 13;

  localparam logic signed [47:0] P_A = -48'sd1310705;
  localparam logic signed [47:0] P_B = 48'sd786408;
  localparam logic signed [47:0] P_X = 48'sd536875008;

  logic                clk;
  logic                rst;
  logic                i_start;
  logic [LW-1:0]       i_len;
  logic                i_valid;
  logic signed [47:0]  i_packed;
  logic                o_ready;
  logic signed [23:0]  o_psum_0;
  logic signed [23:0]  o_psum_1;
  logic                o_valid;
  logic                i_ready;
  logic                o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  packed_psum_unpacker #(
    .MAC_ACC_WIDTH (48),
    .LANE_SHIFT    (17),
    .PSUM_WIDTH    (24),
    .LEN_WIDTH     (LW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_len    (i_len),
    .i_valid  (i_valid),
    .i_packed (i_packed),
    .o_ready  (o_ready),
    .o_psum_0 (o_psum_0),
    .o_psum_1 (o_psum_1),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_busy   (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len);
    i_start = 1'b1;
    i_len   = LW'(len);
    step();
    i_start = 1'b0;
  endtask

  task automatic send_beat(input logic signed [47:0] p);
    i_valid  = 1'b1;
    i_packed = p;
    step();
    i_valid  = 1'b0;
  endtask

  task automatic finish_job();
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({o_ready, o_valid, o_busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000", {o_ready, o_valid, o_busy});
    end
    n_checks++;
    if (o_psum_0 !== 24'sd0 || o_psum_1 !== 24'sd0) begin
      n_fail++;
      $display("FAIL reset_psum: got %0d/%0d expected 0/0", o_psum_0, o_psum_1);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (o_busy !== 1'b0 || o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b ready=%b expected 0/0", o_busy, o_ready);
    end
  endtask

  task automatic test_single_decode();
    start_job(1);
    n_checks++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_latency: o_ready=%b expected 1", o_ready);
    end
    send_beat(P_A);
    n_checks++;
    if (o_valid !== 1'b1 || o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_valid: valid=%b ready=%b expected 1/0", o_valid, o_ready);
    end
    n_checks++;
    if (o_psum_0 !== 24'sd15 || o_psum_1 !== -24'sd10) begin
      n_fail++;
      $display("FAIL single_decode: got %0d/%0d expected 15/-10", o_psum_0, o_psum_1);
    end
    finish_job();
    n_checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL handoff_idle: valid=%b busy=%b expected 0/0", o_valid, o_busy);
    end
    start_job(1);
    send_beat(P_B);
    n_checks++;
    if (o_psum_0 !== -24'sd24 || o_psum_1 !== 24'sd6) begin
      n_fail++;
      $display("FAIL borrow_decode: got %0d/%0d expected -24/6", o_psum_0, o_psum_1);
    end
    finish_job();
  endtask

  task automatic test_accumulate();
    start_job(3);
    send_beat(P_A);
    send_beat(P_A);
    step();
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_not_counted: valid=%b ready=%b expected 0/1", o_valid, o_ready);
    end
    send_beat(P_A);
    n_checks++;
    if (o_valid !== 1'b1 || o_psum_0 !== 24'sd45 || o_psum_1 !== -24'sd30) begin
      n_fail++;
      $display("FAIL accumulate: valid=%b got %0d/%0d expected 1 45/-30", o_valid, o_psum_0, o_psum_1);
    end
    finish_job();
  endtask

  task automatic test_backpressure();
    start_job(1);
    send_beat(P_B);
    for (int k = 0; k < 5; k++) begin
      i_valid  = 1'b1;
      i_packed = P_A;
      i_ready  = 1'b0;
      step();
      n_checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_psum_0 !== -24'sd24 || o_psum_1 !== 24'sd6) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: valid=%b ready=%b got %0d/%0d expected 1/0 -24/6",
                 k, o_valid, o_ready, o_psum_0, o_psum_1);
      end
    end
    i_valid = 1'b0;
    finish_job();
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_release: busy=%b expected 0", o_busy);
    end
  endtask

  task automatic test_back_to_back();
    start_job(1);
    send_beat(P_A);
    i_ready = 1'b1;
    i_start = 1'b1;
    i_len   = LW'(2);
    step();
    i_ready = 1'b0;
    i_start = 1'b0;
    n_checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_restart: ready=%b valid=%b busy=%b expected 1/0/1", o_ready, o_valid, o_busy);
    end
    n_checks++;
    if (o_psum_0 !== 24'sd0 || o_psum_1 !== 24'sd0) begin
      n_fail++;
      $display("FAIL b2b_cleared: got %0d/%0d expected 0/0", o_psum_0, o_psum_1);
    end
    send_beat(P_B);
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_len2_early: valid=%b expected 0", o_valid);
    end
    send_beat(P_B);
    n_checks++;
    if (o_valid !== 1'b1 || o_psum_0 !== -24'sd48 || o_psum_1 !== 24'sd12) begin
      n_fail++;
      $display("FAIL b2b_second_job: valid=%b got %0d/%0d expected 1 -48/12", o_valid, o_psum_0, o_psum_1);
    end
    finish_job();
  endtask

  task automatic test_extremes();
    start_job(1);
    send_beat(P_X);
    n_checks++;
    if (o_psum_0 !== 24'sd4096 || o_psum_1 !== 24'sd4096) begin
      n_fail++;
      $display("FAIL extreme_product: got %0d/%0d expected 4096/4096", o_psum_0, o_psum_1);
    end
    finish_job();
    start_job(0);
    send_beat(P_A);
    n_checks++;
    if (o_valid !== 1'b1 || o_psum_0 !== 24'sd15 || o_psum_1 !== -24'sd10) begin
      n_fail++;
      $display("FAIL len_zero: valid=%b got %0d/%0d expected 1 15/-10", o_valid, o_psum_0, o_psum_1);
    end
    finish_job();
  endtask

  task automatic test_wrap();
    start_job(2048);
    i_valid  = 1'b1;
    i_packed = P_X;
    repeat (2047) step();
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_early_done: valid=%b expected 0", o_valid);
    end
    step();
    i_valid = 1'b0;
    n_checks++;
    if (o_valid !== 1'b1 || o_psum_0 !== -24'sd8388608 || o_psum_1 !== -24'sd8388608) begin
      n_fail++;
      $display("FAIL wrap_2048: valid=%b got %0d/%0d expected 1 -8388608/-8388608", o_valid, o_psum_0, o_psum_1);
    end
    finish_job();
    start_job(4096);
    i_valid  = 1'b1;
    i_packed = P_X;
    repeat (4096) step();
    i_valid = 1'b0;
    n_checks++;
    if (o_valid !== 1'b1 || o_psum_0 !== 24'sd0 || o_psum_1 !== 24'sd0) begin
      n_fail++;
      $display("FAIL wrap_4096: valid=%b got %0d/%0d expected 1 0/0", o_valid, o_psum_0, o_psum_1);
    end
    finish_job();
  endtask

  task automatic test_reset_mid_job();
    start_job(4);
    send_beat(P_X);
    send_beat(P_X);
    n_checks++;
    if (o_psum_0 !== 24'sd8192 || o_psum_1 !== 24'sd8192 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_acc: valid=%b got %0d/%0d expected 0 8192/8192", o_valid, o_psum_0, o_psum_1);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (o_psum_0 !== 24'sd0 || o_psum_1 !== 24'sd0 || o_busy !== 1'b0 || o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got %0d/%0d busy=%b ready=%b expected 0/0 0/0",
               o_psum_0, o_psum_1, o_busy, o_ready);
    end
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: valid=%b busy=%b expected 0/0", o_valid, o_busy);
    end
    start_job(1);
    send_beat(P_A);
    n_checks++;
    if (o_valid !== 1'b1 || o_psum_0 !== 24'sd15 || o_psum_1 !== -24'sd10) begin
      n_fail++;
      $display("FAIL post_reset_job: valid=%b got %0d/%0d expected 1 15/-10", o_valid, o_psum_0, o_psum_1);
    end
    finish_job();
  endtask

  initial begin
    rst      = 1'b1;
    i_start  = 1'b0;
    i_len    = '0;
    i_valid  = 1'b0;
    i_packed = '0;
    i_ready  = 1'b0;
    test_reset();
    test_single_decode();
    test_accumulate();
    test_backpressure();
    test_back_to_back();
    test_extremes();
    test_wrap();
    test_reset_mid_job();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
